// File: rtl/imm_raster_feeder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// imm_raster_feeder
//
// Front end of the image masking pipeline. A start pulse launches a raster
// scan (row-major, column fastest) of the image held in a synchronous BRAM.
// Every pixel is handed to the masking stage together with its row, column
// and the mask offsets latched when that frame was started.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 one-cycle frame request (ignored while busy)
//   stall                 downstream hold; 1 freezes every output register
//   mask_*_offset_in      mask offsets, sampled on an accepted start
//   rd_en, rd_addr        BRAM read request (registered)
//   rd_data               BRAM data, valid the cycle after the rd_en edge
//   pixel_valid           qualifies image_pixel / pixel_row / pixel_col
//   image_pixel           pixel colour
//   pixel_row, pixel_col  raster position of image_pixel
//   mask_*_offset         frame-latched mask offsets
//   frame_first/last      flags on pixel (0,0) and on the final pixel
//   busy                  accepted start .. done
//   done                  one-cycle pulse after the final pixel is accepted
//
// Handshake: a pixel is transferred on every rising edge where pixel_valid=1
// and stall=0. While stall=1 all outputs hold, including pixel_valid, so the
// same pixel is re-presented until an edge with stall=0.
//
// Pipeline: issue (rd_en/rd_addr + s1 tags) -> data stage (rd_data + d tags)
// -> output registers. When stall rises, the pixel sitting on rd_data is
// parked in a one-entry skid register; the read already in flight lands on
// rd_data and stays there because rd_en is held low for the rest of the stall
// (the BRAM read port is enable-gated and keeps its output while rd_en=0).
// On release the skid entry goes out first, then the held rd_data word.
// ---------------------------------------------------------------------------
module imm_raster_feeder #(
  parameter int IMG_ROWS = 240,
  parameter int IMG_COLS = 320,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic [7:0]        mask_row_offset_in,
  input  logic [8:0]        mask_col_offset_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic              pixel_valid,
  output logic [11:0]       image_pixel,
  output logic [7:0]        pixel_row,
  output logic [8:0]        pixel_col,
  output logic [7:0]        mask_row_offset,
  output logic [8:0]        mask_col_offset,
  output logic              frame_first,
  output logic              frame_last,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] LAST_ROW = 8'(IMG_ROWS - 1);
  localparam logic [8:0] LAST_COL = 9'(IMG_COLS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Scan counters: position of the next read to issue.
  logic [7:0]        row_cnt;
  logic [8:0]        col_cnt;
  logic [ADDR_W-1:0] addr_cnt;

  // Position used by this cycle's issue; an accepted start issues (0,0)
  // directly, whatever the counters were left at by the previous frame.
  logic [7:0]        cur_row;
  logic [8:0]        cur_col;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_last;

  logic start_acc;
  logic issue;
  logic last_accept;

  // Tags for the read issued on the last edge (valid while rd_en=1).
  logic [7:0] s1_row;
  logic [8:0] s1_col;
  logic       s1_first;
  logic       s1_last;

  // Tags for the word currently on rd_data, not yet passed on.
  logic       d_valid;
  logic [7:0] d_row;
  logic [8:0] d_col;
  logic       d_first;
  logic       d_last;
  logic       d_take;
  logic       d_park;

  // One-entry skid register.
  logic        skid_valid;
  logic [11:0] skid_data;
  logic [7:0]  skid_row;
  logic [8:0]  skid_col;
  logic        skid_first;
  logic        skid_last;

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  always_comb begin
    start_acc   = (state == IDLE) && start;
    issue       = ((state == SCAN) || start_acc) && !stall;
    cur_row     = (state == IDLE) ? 8'd0 : row_cnt;
    cur_col     = (state == IDLE) ? 9'd0 : col_cnt;
    cur_addr    = (state == IDLE) ? '0 : addr_cnt;
    cur_last    = (cur_row == LAST_ROW) && (cur_col == LAST_COL);
    last_accept = pixel_valid && frame_last && !stall;
    // Data-stage word leaves either to the output or into the skid.
    d_take      = d_valid && !stall && !skid_valid;
    d_park      = d_valid && stall && !skid_valid;
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // A one-pixel image issues its only read on the start edge.
        if (start) state_nxt = (issue && cur_last) ? DRAIN : SCAN;
      end
      SCAN: begin
        if (issue && cur_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Scan counters (addr is a running count, no row*cols product)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt  <= 8'd0;
      col_cnt  <= 9'd0;
      addr_cnt <= '0;
    end else if (issue) begin
      addr_cnt <= cur_addr + 1'b1;
      if (cur_col == LAST_COL) begin
        col_cnt <= 9'd0;
        row_cnt <= cur_row + 8'd1;
      end else begin
        col_cnt <= cur_col + 9'd1;
        row_cnt <= cur_row;
      end
    end else if (start_acc) begin
      row_cnt  <= 8'd0;
      col_cnt  <= 9'd0;
      addr_cnt <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Frame control: offsets, busy, done
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_row_offset <= 8'd0;
      mask_col_offset <= 9'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= (state == DRAIN) && last_accept;
      if (start_acc) begin
        mask_row_offset <= mask_row_offset_in;
        mask_col_offset <= mask_col_offset_in;
        busy            <= 1'b1;
      end else if ((state == DRAIN) && last_accept) begin
        busy <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read issue stage
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      s1_row   <= 8'd0;
      s1_col   <= 9'd0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      rd_en <= issue;
      if (issue) begin
        rd_addr  <= cur_addr;
        s1_row   <= cur_row;
        s1_col   <= cur_col;
        s1_first <= (cur_row == 8'd0) && (cur_col == 9'd0);
        s1_last  <= cur_last;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Data stage: tags follow the BRAM, which loads whenever rd_en was high.
  // rd_en is never high while the skid is full, so a held word is never
  // overwritten before it has moved on.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid <= 1'b0;
      d_row   <= 8'd0;
      d_col   <= 9'd0;
      d_first <= 1'b0;
      d_last  <= 1'b0;
    end else if (rd_en) begin
      d_valid <= 1'b1;
      d_row   <= s1_row;
      d_col   <= s1_col;
      d_first <= s1_first;
      d_last  <= s1_last;
    end else if (d_take || d_park) begin
      d_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Skid register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_data  <= 12'd0;
      skid_row   <= 8'd0;
      skid_col   <= 9'd0;
      skid_first <= 1'b0;
      skid_last  <= 1'b0;
    end else if (d_park) begin
      skid_valid <= 1'b1;
      skid_data  <= rd_data;
      skid_row   <= d_row;
      skid_col   <= d_col;
      skid_first <= d_first;
      skid_last  <= d_last;
    end else if (!stall && skid_valid) begin
      skid_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Output registers: frozen under stall; skid entry has priority.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid <= 1'b0;
      image_pixel <= 12'd0;
      pixel_row   <= 8'd0;
      pixel_col   <= 9'd0;
      frame_first <= 1'b0;
      frame_last  <= 1'b0;
    end else if (!stall) begin
      if (skid_valid) begin
        pixel_valid <= 1'b1;
        image_pixel <= skid_data;
        pixel_row   <= skid_row;
        pixel_col   <= skid_col;
        frame_first <= skid_first;
        frame_last  <= skid_last;
      end else if (d_valid) begin
        pixel_valid <= 1'b1;
        image_pixel <= rd_data;
        pixel_row   <= d_row;
        pixel_col   <= d_col;
        frame_first <= d_first;
        frame_last  <= d_last;
      end else begin
        // Data fields keep their last values; only the qualifiers drop.
        pixel_valid <= 1'b0;
        frame_first <= 1'b0;
        frame_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_raster_feeder.sv
`timescale 1ns/1ps
// Bench for imm_raster_feeder on a 4x5 image. The expected pixel stream of a
// frame is generated on an accepted start as a list of (row, col, data,
// first, last) entries derived from k/COLS, k%COLS and the image memory, and
// is popped each time the DUT transfers a pixel (pixel_valid=1, stall=0).
module tb_imm_raster_feeder;

  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int AW   = 5;
  localparam int NPIX = ROWS * COLS;
  localparam int W    = 31; // {first, last, row[8], col[9], data[12]}

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start;
  logic          stall;
  logic [7:0]    mask_row_offset_in;
  logic [8:0]    mask_col_offset_in;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [11:0]   rd_data;
  logic          pixel_valid;
  logic [11:0]   image_pixel;
  logic [7:0]    pixel_row;
  logic [8:0]    pixel_col;
  logic [7:0]    mask_row_offset;
  logic [8:0]    mask_col_offset;
  logic          frame_first;
  logic          frame_last;
  logic          busy;
  logic          done;

  imm_raster_feeder #(
    .IMG_ROWS (ROWS),
    .IMG_COLS (COLS),
    .ADDR_W   (AW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .stall              (stall),
    .mask_row_offset_in (mask_row_offset_in),
    .mask_col_offset_in (mask_col_offset_in),
    .rd_en              (rd_en),
    .rd_addr            (rd_addr),
    .rd_data            (rd_data),
    .pixel_valid        (pixel_valid),
    .image_pixel        (image_pixel),
    .pixel_row          (pixel_row),
    .pixel_col          (pixel_col),
    .mask_row_offset    (mask_row_offset),
    .mask_col_offset    (mask_col_offset),
    .frame_first        (frame_first),
    .frame_last         (frame_last),
    .busy               (busy),
    .done               (done)
  );

  // Enable-gated synchronous BRAM
  logic [11:0] mem [0:31];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // ---------------------------------------------------------------- model state
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  logic         busy_m = 1'b0;
  logic         frame_stalled = 1'b0;
  logic [7:0]   exp_mro = 8'd0;
  logic [8:0]   exp_mco = 9'd0;
  int           guard;
  logic         flag;

  // ---------------------------------------------------------------- scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},     32'(rd_en), 32'd0);
    check({tag, "_rd_addr"},   32'(rd_addr), 32'd0);
    check({tag, "_valid"},     32'(pixel_valid), 32'd0);
    check({tag, "_pixel"},     32'(image_pixel), 32'd0);
    check({tag, "_row"},       32'(pixel_row), 32'd0);
    check({tag, "_col"},       32'(pixel_col), 32'd0);
    check({tag, "_mro"},       32'(mask_row_offset), 32'd0);
    check({tag, "_mco"},       32'(mask_col_offset), 32'd0);
    check({tag, "_first"},     32'(frame_first), 32'd0);
    check({tag, "_last"},      32'(frame_last), 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_done"},      32'(done), 32'd0);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic load_mem(input logic ramp);
    for (int i = 0; i < 32; i++)
      mem[i] = ramp ? 12'(i) : 12'($urandom_range(0, 4095));
  endtask

  // One clock cycle: drive inputs, score the pixel on the outputs now (it is
  // transferred at the coming edge iff valid and not stalled), update the
  // model for the edge, then check the registered frame status after it.
  task automatic step(input logic st, input logic sl,
                      input logic [7:0] mro, input logic [8:0] mco);
    logic [W-1:0] e;
    logic         acc_last;
    start = st;
    stall = sl;
    mask_row_offset_in = mro;
    mask_col_offset_in = mco;
    acc_last = 1'b0;
    if (pixel_valid && !sl) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", 32'(pixel_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pix_row",   32'(pixel_row),   32'(e[28:21]));
        check("pix_col",   32'(pixel_col),   32'(e[20:12]));
        check("pix_data",  32'(image_pixel), 32'(e[11:0]));
        check("pix_first", 32'(frame_first), 32'(e[30]));
        check("pix_last",  32'(frame_last),  32'(e[29]));
        if (e[30] && !frame_stalled) check("first_latency", 32'(cyc - start_cyc), 32'd3);
        if (e[29]) begin
          acc_last = 1'b1;
          if (!frame_stalled) check("frame_span", 32'(cyc - start_cyc), 32'(NPIX + 2));
        end
      end
    end else if (!pixel_valid) begin
      check("idle_first", 32'(frame_first), 32'd0);
      check("idle_last",  32'(frame_last),  32'd0);
    end
    if (busy_m && sl) frame_stalled = 1'b1;
    if (st && !busy_m) begin
      busy_m = 1'b1;
      exp_mro = mro;
      exp_mco = mco;
      start_cyc = cyc;
      frame_stalled = sl;
      exp_q.delete();
      for (int k = 0; k < NPIX; k++)
        exp_q.push_back({k == 0, k == NPIX - 1, 8'(k / COLS), 9'(k % COLS), mem[k]});
    end
    if (acc_last) busy_m = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done", 32'(done), 32'(acc_last));
    check("busy", 32'(busy), 32'(busy_m));
    check("mask_row_offset", 32'(mask_row_offset), 32'(exp_mro));
    check("mask_col_offset", 32'(mask_col_offset), 32'(exp_mco));
    cyc++;
  endtask

  // mode 0: no stall, 1: stall toggles every cycle, 2: random stall
  task automatic run_until_idle(input int mode, input int budget);
    int   n;
    logic tog;
    logic sl;
    n = 0;
    tog = 1'b1;
    while (busy_m && n < budget) begin
      case (mode)
        1:       begin sl = tog; tog = ~tog; end
        2:       sl = ($urandom_range(0, 3) == 0);
        default: sl = 1'b0;
      endcase
      step(1'b0, sl, 8'd0, 9'd0);
      n++;
    end
    check("frame_finished", 32'(busy), 32'd0);
    check("stream_consumed", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    mask_row_offset_in = 8'd0;
    mask_col_offset_in = 9'd0;
    load_mem(1'b1);
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Stall while idle has no effect
    step(1'b0, 1'b1, 8'd0, 9'd0);
    step(1'b0, 1'b0, 8'd0, 9'd0);

    // Frame A: data = address, offsets (2,3), no stall
    load_mem(1'b1);
    step(1'b1, 1'b0, 8'd2, 9'd3);
    run_until_idle(0, 60);
    step(1'b0, 1'b0, 8'd0, 9'd0);

    // Frame B: 3-cycle stall while pixel 7 (1,2) is on the output
    load_mem(1'b0);
    step(1'b1, 1'b0, 8'd2, 9'd3);
    guard = 0;
    flag = 1'b0;
    while (busy_m && guard < 100) begin
      if (!flag && pixel_valid && pixel_row == 8'd1 && pixel_col == 9'd2) begin
        for (int i = 0; i < 3; i++) begin
          step(1'b0, 1'b1, 8'd0, 9'd0);
          check("p7_hold_valid", 32'(pixel_valid), 32'd1);
          check("p7_hold_row",   32'(pixel_row),   32'd1);
          check("p7_hold_col",   32'(pixel_col),   32'd2);
        end
        flag = 1'b1;
      end else begin
        step(1'b0, 1'b0, 8'd0, 9'd0);
      end
      guard++;
    end
    check("p7_stall_applied", 32'(flag), 32'd1);
    check("frame_b_idle", 32'(busy), 32'd0);

    // Frame C: stall toggling every cycle
    load_mem(1'b0);
    step(1'b1, 1'b0, 8'd2, 9'd3);
    run_until_idle(1, 120);

    // Frame D: second start at pixel 10 with (9,9) must be ignored
    load_mem(1'b0);
    step(1'b1, 1'b0, 8'd2, 9'd3);
    guard = 0;
    flag = 1'b0;
    while (busy_m && guard < 100) begin
      if (!flag && pixel_valid && pixel_row == 8'd2 && pixel_col == 9'd0) begin
        step(1'b1, 1'b0, 8'd9, 9'd9);
        flag = 1'b1;
      end else begin
        step(1'b0, 1'b0, 8'd0, 9'd0);
      end
      guard++;
    end
    check("restart_applied", 32'(flag), 32'd1);
    check("frame_d_idle", 32'(busy), 32'd0);

    // Frame E: asynchronous reset while pixel 12 (2,2) is on the output
    load_mem(1'b1);
    step(1'b1, 1'b0, 8'd7, 9'd11);
    guard = 0;
    while (guard < 60 && !(pixel_valid && pixel_row == 8'd2 && pixel_col == 9'd2)) begin
      step(1'b0, 1'b0, 8'd0, 9'd0);
      guard++;
    end
    check("p12_reached", 32'(pixel_valid && pixel_col == 9'd2), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    busy_m = 1'b0;
    exp_mro = 8'd0;
    exp_mco = 9'd0;
    step(1'b0, 1'b0, 8'd0, 9'd0);
    step(1'b0, 1'b0, 8'd0, 9'd0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'd0, 9'd0);
    step(1'b1, 1'b0, 8'd5, 9'd7);
    run_until_idle(0, 60);

    // Frame F: start together with stall; stall released 4 cycles later
    load_mem(1'b0);
    step(1'b1, 1'b1, 8'd4, 9'd6);
    check("ss_rd_en_0", 32'(rd_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'd0, 9'd0);
      check("ss_rd_en_held", 32'(rd_en), 32'd0);
    end
    step(1'b0, 1'b0, 8'd0, 9'd0);
    check("ss_rd_en_first", 32'(rd_en), 32'd1);
    check("ss_rd_addr_first", 32'(rd_addr), 32'd0);
    step(1'b0, 1'b0, 8'd0, 9'd0);
    check("ss_valid_early", 32'(pixel_valid), 32'd0);
    step(1'b0, 1'b0, 8'd0, 9'd0);
    check("ss_valid_first", 32'(pixel_valid), 32'd1);
    check("ss_row_first", 32'(pixel_row), 32'd0);
    check("ss_col_first", 32'(pixel_col), 32'd0);
    check("ss_data_first", 32'(image_pixel), 32'(mem[0]));
    run_until_idle(0, 60);

    // Randomised frames: random image, offsets and stall pattern
    for (int f = 0; f < 4; f++) begin
      load_mem(1'b0);
      step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           9'($urandom_range(0, 511)));
      run_until_idle(2, 200);
      step(1'b0, 1'($urandom_range(0, 1)), 8'd0, 9'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
